// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB TX sequencer.
// The CRC states exist only when USB_TX_CRC16_EN is defined.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
`ifdef USB_TX_CRC16_EN
    ST_CRC_LO,
    ST_CRC_HI,
`endif
    ST_EOP
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'h01;

  localparam logic [1:0]  PID_TYPE_SPECIAL   = 2'b00;
  localparam logic [1:0]  PID_TYPE_TOKEN     = 2'b01;
  localparam logic [1:0]  PID_TYPE_HANDSHAKE = 2'b10;
  localparam logic [1:0]  PID_TYPE_DATA      = 2'b11;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wise CRC16 (poly 0x8005, byte bits consumed LSB-first) with clear/enable.
// Only built when USB_TX_CRC16_EN is defined.
`ifdef USB_TX_CRC16_EN
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ CRC16_POLY) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_byte(crc, data);
    end
  end

endmodule
`endif

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: drives the TX parallel-to-serial shifter through SYNC, PID, payload,
// optional CRC16 (USB_TX_CRC16_EN) and EOP for one USB packet.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned EOP_BITS     = 3,
  parameter int unsigned MAX_LEN      = 64,
  localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_req,
  output logic             pts_load,
  output logic             pts_shift,
  output logic [7:0]       pts_data,
  output logic             eop_req,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_err
);

  localparam int unsigned      CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned      EOP_CYC  = EOP_BITS * CLKS_PER_BIT;
  localparam int unsigned      EW       = (EOP_CYC > 1) ? $clog2(EOP_CYC) : 1;
  localparam logic [CW-1:0]    CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [EW-1:0]    EOP_LAST = EW'(EOP_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  state_t           state_q, state_d, after_data;
  logic [CW-1:0]    clk_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [LEN_W-1:0] byte_cnt_q;
  logic [3:0]       pid_q;
  logic [7:0]       hold_q, load_val;
  logic [EW-1:0]    eop_cnt_q;
  logic             done_q, accept, in_slot, tick, slot_first, slot_end;

  // A start coinciding with the done pulse is dropped so back-to-back packets keep a gap.
  assign accept     = (state_q == ST_IDLE) && tx_start && !done_q;
  assign tick       = (clk_cnt_q == '0);
  assign slot_first = tick && (bit_cnt_q == 3'd0);
  assign slot_end   = (clk_cnt_q == CLK_LAST) && (bit_cnt_q == 3'd7);
  assign in_slot    = !(state_q inside {ST_IDLE, ST_EOP});

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc;

  assign after_data = (pid_q[1:0] == PID_TYPE_DATA) ? ST_CRC_LO : ST_EOP;

  usb_crc16 u_crc16 (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (accept),
    .en    (byte_req),
    .data  (byte_in),
    .crc   (crc)
  );
`else
  assign after_data = ST_EOP;
`endif

  always_comb begin
    state_d   = state_q;
    load_val  = hold_q;
    pts_load  = 1'b0;
    pts_shift = in_slot && tick && (bit_cnt_q != 3'd0);
    byte_req  = 1'b0;
    tx_err    = 1'b0;
    eop_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        load_val = SYNC_BYTE;
        pts_load = slot_first;
        if (slot_end) state_d = ST_PID;
      end
      ST_PID: begin
        load_val = bitrev8({~pid_q, pid_q});
        pts_load = slot_first;
        if (slot_end) state_d = (byte_cnt_q != '0) ? ST_DATA : after_data;
      end
      ST_DATA: begin
        load_val = bitrev8(byte_in);
        if (slot_first) begin
          if (byte_valid) begin
            pts_load = 1'b1;
            byte_req = 1'b1;
          end else begin
            tx_err  = 1'b1;
            state_d = ST_EOP;
          end
        end else if (slot_end && (byte_cnt_q == LEN_W'(1))) begin
          state_d = after_data;
        end
      end
`ifdef USB_TX_CRC16_EN
      ST_CRC_LO: begin
        load_val = bitrev8(~crc[7:0]);
        pts_load = slot_first;
        if (slot_end) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        load_val = bitrev8(~crc[15:8]);
        pts_load = slot_first;
        if (slot_end) state_d = ST_EOP;
      end
`endif
      ST_EOP: begin
        eop_req = 1'b1;
        if (eop_cnt_q == EOP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pid_q      <= '0;
      hold_q     <= '0;
      eop_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_EOP) && (state_d == ST_IDLE);
      if (accept) begin
        byte_cnt_q <= (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
        pid_q      <= tx_pid;
        clk_cnt_q  <= '0;
        bit_cnt_q  <= '0;
      end else if (in_slot) begin
        clk_cnt_q <= (clk_cnt_q == CLK_LAST) ? '0 : clk_cnt_q + CW'(1);
        if (clk_cnt_q == CLK_LAST) bit_cnt_q <= bit_cnt_q + 3'd1;
        if ((state_q == ST_DATA) && slot_end) byte_cnt_q <= byte_cnt_q - LEN_W'(1);
      end
      eop_cnt_q <= (state_q == ST_EOP) ? eop_cnt_q + EW'(1) : '0;
      if (pts_load) begin
        hold_q <= load_val;
      end else if (state_d == ST_IDLE) begin
        hold_q <= '0;
      end
    end
  end

  assign pts_data = pts_load ? load_val : hold_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = done_q;

endmodule
